itch_feed_arbiter: RTL and testbench

ITCH_FEED_ARBITER -- requirements
Module: itch_feed_arbiter

---
 rtl/itch_pkg.sv | 33 +++
 rtl/itch_feed_arbiter_rr_arb2.sv | 24 ++
 rtl/itch_feed_arbiter.sv | 170 +++++++++++++++++
 tb/tb_itch_feed_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/itch_pkg.sv
// ITCH message-type constants, type-to-length lookup and the arbiter state
// encoding shared by the feed arbiter and its bench-facing logic.
package itch_pkg;

  localparam logic [7:0] ITCH_ADD_ORDER    = 8'h41;  // 'A'
  localparam logic [7:0] ITCH_EXECUTED     = 8'h45;  // 'E'
  localparam logic [7:0] ITCH_CANCEL       = 8'h58;  // 'X'
  localparam logic [7:0] ITCH_DELETE       = 8'h44;  // 'D'
  localparam logic [7:0] ITCH_REPLACE      = 8'h55;  // 'U'
  localparam logic [7:0] ITCH_ADD_ATTRIB   = 8'h46;  // 'F'

  localparam int LEN_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  // Zero marks a type the parser does not understand.
  function automatic logic [LEN_W-1:0] itch_msg_len(input logic [7:0] msg_type);
    case (msg_type)
      ITCH_ADD_ORDER:  itch_msg_len = LEN_W'(36);
      ITCH_EXECUTED:   itch_msg_len = LEN_W'(31);
      ITCH_CANCEL:     itch_msg_len = LEN_W'(23);
      ITCH_DELETE:     itch_msg_len = LEN_W'(19);
      ITCH_REPLACE:    itch_msg_len = LEN_W'(35);
      ITCH_ADD_ATTRIB: itch_msg_len = LEN_W'(40);
      default:         itch_msg_len = '0;
    endcase
  endfunction

endpackage

// File: rtl/itch_feed_arbiter_rr_arb2.sv
// Two-way round-robin grant: the source not served last wins a tie; the
// priority only moves when a granted message completes.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_done,
  input  logic       i_done_id,
  output logic       o_winner
);

  logic r_prio;

  assign o_winner = (&i_req) ? r_prio : i_req[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= 1'b0;
    end else if (i_done) begin
      r_prio <= ~i_done_id;
    end
  end

endmodule

// File: rtl/itch_feed_arbiter.sv
// Shares one ITCH parser between two byte-serial feeds at message granularity,
// dropping unknown message types and counting length mismatches.
module itch_feed_arbiter
  import itch_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            src_valid,
  input  logic [1:0][7:0]       src_data,
  input  logic [1:0]            src_last,
  output logic [1:0]            src_ready,
  output logic                  start_msg,
  output logic                  end_msg,
  output logic [7:0]            message,
  output logic                  valid,
  output logic                  grant_id,
  output logic                  busy,
  output logic [CNT_W-1:0]      msg_cnt,
  output logic [CNT_W-1:0]      drop_cnt,
  output logic [CNT_W-1:0]      len_err_cnt
);

  state_e             r_state;
  logic               r_grant;
  logic [LEN_W-1:0]   r_rem;
  logic               r_start;
  logic               r_end;
  logic [7:0]         r_msg;
  logic               r_valid;
  logic               r_busy;
  logic [CNT_W-1:0]   r_msg_cnt;
  logic [CNT_W-1:0]   r_drop_cnt;
  logic [CNT_W-1:0]   r_len_err_cnt;

  logic               w_winner;
  logic               w_sel;
  logic [1:0]         w_ready;
  logic               w_xfer;
  logic [7:0]         w_byte;
  logic               w_last;
  logic [LEN_W-1:0]   w_type_len;
  logic               w_known;
  logic               w_done;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (src_valid),
    .i_done    (w_done),
    .i_done_id (w_sel),
    .o_winner  (w_winner)
  );

  assign w_sel = (r_state == ST_IDLE) ? w_winner : r_grant;

  always_comb begin
    // NOTE: default first so every path assigns w_ready and no latch is inferred.
    w_ready = 2'b00;
    case (r_state)
      ST_IDLE:         if (|src_valid) w_ready[w_winner] = 1'b1;
      ST_FWD, ST_DROP: w_ready[r_grant] = 1'b1;
      default:         w_ready = 2'b00;
    endcase
  end

  // NOTE: ready is combinational from src_valid, so it is masked while reset is held.
  assign src_ready  = w_ready & {2{rst_n}};

  assign w_xfer     = src_valid[w_sel] & w_ready[w_sel];
  assign w_byte     = src_data[w_sel];
  assign w_last     = src_last[w_sel];
  assign w_type_len = itch_msg_len(w_byte);
  assign w_known    = (w_type_len != '0);
  assign w_done     = w_xfer & w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_grant       <= 1'b0;
      r_rem         <= '0;
      r_start       <= 1'b0;
      r_end         <= 1'b0;
      r_msg         <= '0;
      r_valid       <= 1'b0;
      r_busy        <= 1'b0;
      r_msg_cnt     <= '0;
      r_drop_cnt    <= '0;
      r_len_err_cnt <= '0;
    end else begin
      // NOTE: non-blocking throughout; parser pins fall back to 0 unless a byte moves.
      r_start <= 1'b0;
      r_end   <= 1'b0;
      r_valid <= 1'b0;
      r_msg   <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            r_grant <= w_winner;
            if (w_known) begin
              r_start <= 1'b1;
              r_valid <= 1'b1;
              r_msg   <= w_byte;
              r_end   <= w_last;
              r_rem   <= w_type_len - LEN_W'(1);
              if (w_last) begin
                r_msg_cnt     <= sat_inc(r_msg_cnt);
                r_len_err_cnt <= sat_inc(r_len_err_cnt);
              end else begin
                r_state <= ST_FWD;
                r_busy  <= 1'b1;
              end
            end else begin
              r_rem <= '0;
              if (w_last) begin
                r_drop_cnt <= sat_inc(r_drop_cnt);
              end else begin
                r_state <= ST_DROP;
                r_busy  <= 1'b1;
              end
            end
          end
        end
        ST_FWD: begin
          if (w_xfer) begin
            r_valid <= 1'b1;
            r_msg   <= w_byte;
            r_end   <= w_last;
            r_rem   <= (r_rem == '0) ? '0 : r_rem - LEN_W'(1);
            if (w_last) begin
              r_state   <= ST_IDLE;
              r_busy    <= 1'b0;
              r_rem     <= '0;
              r_msg_cnt <= sat_inc(r_msg_cnt);
              // Exactly one byte must still be outstanding when src_last arrives.
              if (r_rem != LEN_W'(1)) r_len_err_cnt <= sat_inc(r_len_err_cnt);
            end
          end
        end
        ST_DROP: begin
          if (w_done) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_drop_cnt <= sat_inc(r_drop_cnt);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign start_msg   = r_start;
  assign end_msg     = r_end;
  assign message     = r_msg;
  assign valid       = r_valid;
  assign grant_id    = r_grant;
  assign busy        = r_busy;
  assign msg_cnt     = r_msg_cnt;
  assign drop_cnt    = r_drop_cnt;
  assign len_err_cnt = r_len_err_cnt;

endmodule

// File: tb/tb_itch_feed_arbiter.sv
// Randomised and directed bench for itch_feed_arbiter with a message-level
// reference model compared against the DUT every cycle.
module tb_itch_feed_arbiter;

  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       src_valid;
  logic [1:0][7:0]  src_data;
  logic [1:0]       src_last;
  logic [1:0]       src_ready;
  logic             start_msg, end_msg, valid, grant_id, busy;
  logic [7:0]       message;
  logic [CNT_W-1:0] msg_cnt, drop_cnt, len_err_cnt;

  itch_feed_arbiter #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_data(src_data),
    .src_last(src_last), .src_ready(src_ready), .start_msg(start_msg),
    .end_msg(end_msg), .message(message), .valid(valid), .grant_id(grant_id),
    .busy(busy), .msg_cnt(msg_cnt), .drop_cnt(drop_cnt), .len_err_cnt(len_err_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Per-source byte queues: bit 9 = one idle cycle, bit 8 = last, [7:0] = byte.
  logic [9:0] q0[$];
  logic [9:0] q1[$];
  int gap_pct = 0;

  // Reference model: message-level view of who owns the parser.
  bit   m_open;
  int   m_owner, m_prio, m_cnt, m_len;
  int   m_msg, m_drop, m_lerr;
  logic e_start, e_end, e_valid, e_busy, e_grant;
  logic [7:0] e_msg;

  // Observed events from the DUT pins.
  int cyc, n_valid;
  int st_cyc[$], en_cyc[$], st_gnt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int ref_len(input logic [7:0] t);
    case (t)
      8'h41: return 36;
      8'h45: return 31;
      8'h58: return 23;
      8'h44: return 19;
      8'h55: return 35;
      8'h46: return 40;
      default: return 0;
    endcase
  endfunction

  function automatic int sat(input int x);
    return (x < MAXC) ? x + 1 : MAXC;
  endfunction

  function automatic int qsize(input int s);
    return (s == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [9:0] qhead(input int s);
    return (s == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpop(input int s);
    if (s == 0) void'(q0.pop_front()); else void'(q1.pop_front());
  endtask

  task automatic qpush(input int s, input logic [9:0] e);
    if (s == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic push_msg(input int s, input logic [7:0] t, input int len,
                          input int stall_at, input int stall_n);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      if (i == stall_at)
        for (int k = 0; k < stall_n; k++) qpush(s, 10'h200);
      b = (i == 0) ? t : 8'($urandom);
      qpush(s, {1'b0, (i == len - 1), b});
    end
  endtask

  task automatic model_reset();
    m_open = 0; m_owner = 0; m_prio = 0; m_cnt = 0; m_len = 0;
    m_msg = 0; m_drop = 0; m_lerr = 0;
    e_start = 0; e_end = 0; e_valid = 0; e_busy = 0; e_grant = 0; e_msg = '0;
  endtask

  task automatic clear_stats();
    cyc = 0; n_valid = 0;
    st_cyc.delete(); en_cyc.delete(); st_gnt.delete();
  endtask

  // Decide who may send, check ready, then advance the message bookkeeping.
  task automatic model_step(input logic [1:0] v);
    logic [1:0] er;
    int s;
    logic [7:0] b;
    logic l;
    er = 2'b00;
    s  = 0;
    if (m_open) begin
      s = m_owner; er[s] = 1'b1;
    end else if (v != 2'b00) begin
      s = (v == 2'b11) ? m_prio : (v[1] ? 1 : 0);
      er[s] = 1'b1;
    end
    chk("src_ready", 32'(src_ready), 32'(er));
    e_start = 0; e_end = 0; e_valid = 0; e_msg = '0;
    if (v[s] && er[s]) begin
      b = src_data[s];
      l = src_last[s];
      if (!m_open) begin
        m_owner = s; e_grant = 1'(s); m_cnt = 0; m_len = ref_len(b);
      end
      m_cnt++;
      if (m_len != 0) begin
        e_valid = 1; e_msg = b; e_start = (m_cnt == 1); e_end = l;
      end
      if (l) begin
        m_open = 0;
        m_prio = 1 - s;
        if (m_len != 0) begin
          m_msg = sat(m_msg);
          if (m_cnt != m_len) m_lerr = sat(m_lerr);
        end else begin
          m_drop = sat(m_drop);
        end
      end else begin
        m_open = 1;
      end
      e_busy = m_open;
      qpop(s);
    end
  endtask

  task automatic cycle();
    logic [1:0] v;
    logic [9:0] h;
    @(negedge clk);
    cyc++;
    chk("start_msg",   32'(start_msg),   32'(e_start));
    chk("end_msg",     32'(end_msg),     32'(e_end));
    chk("valid",       32'(valid),       32'(e_valid));
    chk("message",     32'(message),     32'(e_msg));
    chk("grant_id",    32'(grant_id),    32'(e_grant));
    chk("busy",        32'(busy),        32'(e_busy));
    chk("msg_cnt",     32'(msg_cnt),     32'(m_msg));
    chk("drop_cnt",    32'(drop_cnt),    32'(m_drop));
    chk("len_err_cnt", 32'(len_err_cnt), 32'(m_lerr));
    if (valid) n_valid++;
    if (start_msg) begin st_cyc.push_back(cyc); st_gnt.push_back(int'(grant_id)); end
    if (end_msg) en_cyc.push_back(cyc);
    v = 2'b00;
    for (int s = 0; s < 2; s++) begin
      src_data[s] = 8'($urandom);
      src_last[s] = 1'b0;
      if (qsize(s) != 0) begin
        h = qhead(s);
        if (h[9]) qpop(s);
        else if (gap_pct == 0 || $urandom_range(0, 99) >= gap_pct) begin
          v[s] = 1'b1; src_data[s] = h[7:0]; src_last[s] = h[8];
        end
      end
    end
    src_valid = v;
    #1;
    model_step(v);
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || m_open) && n < budget) begin
      cycle();
      n++;
    end
    chk("run_budget", 32'(n < budget), 32'd1);
    cycle();
    cycle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    src_valid = 2'b00; src_last = 2'b00;
    q0.delete(); q1.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    clear_stats();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_src_ready"}, 32'(src_ready), 32'd0);
    chk({tag, "_pins"}, 32'({start_msg, end_msg, valid, grant_id, busy}), 32'd0);
    chk({tag, "_message"}, 32'(message), 32'd0);
    chk({tag, "_counters"}, 32'({msg_cnt, drop_cnt, len_err_cnt}), 32'd0);
  endtask

  logic [7:0] types [9] = '{8'h41, 8'h45, 8'h58, 8'h44, 8'h55, 8'h46, 8'h5A, 8'h00, 8'hFF};

  initial begin
    int s, len, n;
    logic [7:0] t;

    // Reset state, with both sources requesting while reset is held.
    rst_n = 1'b0; src_valid = 2'b11; src_last = 2'b11; src_data = '{8'h41, 8'h44};
    model_reset(); clear_stats();
    #23;
    chk_all_zero("reset");
    @(negedge clk); src_valid = 2'b00; src_last = 2'b00; rst_n = 1'b1;

    // Single D message on source 0.
    push_msg(0, 8'h44, 19, -1, 0);
    run_until_idle(200);
    chk("d_start_cycle", 32'(st_cyc.size() == 1 ? st_cyc[0] : -1), 32'd2);
    chk("d_end_delay", 32'(en_cyc.size() == 1 ? en_cyc[0] - st_cyc[0] : -1), 32'd18);
    chk("d_msg_cnt", 32'(msg_cnt), 32'd1);
    chk("d_len_err", 32'(len_err_cnt), 32'd0);

    // Both sources present an A message together.
    do_reset();
    push_msg(0, 8'h41, 36, -1, 0);
    push_msg(1, 8'h41, 36, -1, 0);
    run_until_idle(300);
    chk("aa_starts", 32'(st_cyc.size()), 32'd2);
    chk("aa_grants", 32'({st_gnt[0][0], st_gnt[1][0]}), 32'b01);
    chk("aa_first_len", 32'(en_cyc[0] - st_cyc[0]), 32'd35);
    chk("aa_second_gap", 32'(st_cyc[1] - en_cyc[0]), 32'd1);
    chk("aa_msg_cnt", 32'(msg_cnt), 32'd2);

    // Unknown type on source 1 is dropped; source 0 X follows normally.
    do_reset();
    push_msg(1, 8'h5A, 10, -1, 0);
    run_until_idle(100);
    chk("drop_no_valid", 32'(n_valid), 32'd0);
    chk("drop_cnt", 32'(drop_cnt), 32'd1);
    push_msg(0, 8'h58, 23, -1, 0);
    run_until_idle(100);
    chk("drop_x_valid", 32'(n_valid), 32'd23);
    chk("drop_x_msg_cnt", 32'(msg_cnt), 32'd1);

    // Short X then long E.
    do_reset();
    push_msg(0, 8'h58, 20, -1, 0);
    run_until_idle(100);
    chk("short_end_delay", 32'(en_cyc[0] - st_cyc[0]), 32'd19);
    chk("short_len_err", 32'(len_err_cnt), 32'd1);
    push_msg(0, 8'h45, 33, -1, 0);
    run_until_idle(100);
    chk("long_valid", 32'(n_valid), 32'd53);
    chk("long_len_err", 32'(len_err_cnt), 32'd2);

    // F message with a 2-cycle gap while source 1 waits.
    do_reset();
    push_msg(0, 8'h46, 40, 10, 2);
    push_msg(1, 8'h44, 19, -1, 0);
    run_until_idle(300);
    chk("gap_f_span", 32'(en_cyc[0] - st_cyc[0]), 32'd41);
    chk("gap_grants", 32'({st_gnt[0][0], st_gnt[1][0]}), 32'b01);
    chk("gap_valid", 32'(n_valid), 32'd59);

    // Reset in the middle of a U message.
    do_reset();
    push_msg(0, 8'h55, 35, -1, 0);
    n = 0;
    while (!(m_open && m_cnt == 15) && n < 100) begin cycle(); n++; end
    chk("mid_reset_reach", 32'(n < 100), 32'd1);
    @(posedge clk); #2;
    chk("pre_reset_valid", 32'(valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    src_valid = 2'b00; src_last = 2'b00;
    q0.delete(); q1.delete();
    model_reset(); clear_stats();
    @(negedge clk); rst_n = 1'b1;
    push_msg(0, 8'h44, 19, -1, 0);
    run_until_idle(100);
    chk("post_reset_ends", 32'(en_cyc.size()), 32'd1);
    chk("post_reset_msg_cnt", 32'(msg_cnt), 32'd1);
    chk("post_reset_len_err", 32'(len_err_cnt), 32'd0);

    // Saturation with single-byte messages on both sources.
    do_reset();
    for (int i = 0; i < 17; i++) push_msg(0, 8'h41, 1, -1, 0);
    for (int i = 0; i < 16; i++) push_msg(1, 8'h5A, 1, -1, 0);
    run_until_idle(200);
    chk("sat_msg_cnt", 32'(msg_cnt), 32'(MAXC));
    chk("sat_len_err", 32'(len_err_cnt), 32'(MAXC));
    chk("sat_drop_cnt", 32'(drop_cnt), 32'(MAXC));

    // Randomised traffic with gaps on both feeds.
    do_reset();
    gap_pct = 25;
    for (int i = 0; i < 60; i++) begin
      s = $urandom_range(0, 1);
      t = types[$urandom_range(0, 8)];
      if (ref_len(t) != 0)
        len = ($urandom_range(0, 9) == 0) ? 1 : ref_len(t) + $urandom_range(0, 4) - 2;
      else
        len = $urandom_range(1, 8);
      push_msg(s, t, len, -1, 0);
    end
    run_until_idle(20000);
    gap_pct = 0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
